// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller: receiver state
// encoding, parameter defaults, clamp limits for the latched frame
// configuration, and small bit-level helper functions.
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    // Parameter defaults
    localparam int DATA_W_MAX_DEF = 9;   // widest data word (must stay <= 15)
    localparam int PRESC_W_DEF    = 6;   // width of the clocks-per-bit value

    // Clamp limits applied when the frame configuration is latched
    localparam int LEN_MIN   = 5;        // fewest data bits per frame
    localparam int PRESC_MIN = 8;        // fewest clocks per bit

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP1      = 3'd4,
        ST_STOP2      = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } rx_state_e;

    // Expected parity bit for a zero-extended data word.
    function automatic logic exp_parity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Bundles the serial input, the frame configuration and the receive results
// of uart_rx_ctrl.
//   master : drives rx_in and the configuration, observes the results
//   slave  : the receiver side (uart_rx_ctrl)
// Signals: rx_in, prescale[PRESC_W], data_len[4], par_en, par_odd, stop2,
//          data_out[DATA_W_MAX], data_valid, par_err, stp_err, brk_det, busy.
// ----------------------------------------------------------------------------
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_W_MAX = DATA_W_MAX_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
) ();

    logic                  rx_in;
    logic [PRESC_W-1:0]    prescale;
    logic [3:0]            data_len;
    logic                  par_en;
    logic                  par_odd;
    logic                  stop2;
    logic [DATA_W_MAX-1:0] data_out;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  brk_det;
    logic                  busy;

    modport master (
        output rx_in, prescale, data_len, par_en, par_odd, stop2,
        input  data_out, data_valid, par_err, stp_err, brk_det, busy
    );

    modport slave (
        input  rx_in, prescale, data_len, par_en, par_odd, stop2,
        output data_out, data_valid, par_err, stp_err, brk_det, busy
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Bit-timing engine for the receiver. Runs an edge counter 0..P-1 while the
// receiver is active, captures the line at P/2-1 and P/2, and votes those two
// with the live line at P/2+1.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   run         : receiver is outside IDLE; counter held at 0 otherwise
//   rx_in       : synchronised serial line
//   presc       : latched clocks per bit (P)
//   bit_end     : current bit ends this cycle (edge count = P-1)
//   maj_valid   : majority result is valid this cycle (edge count = P/2+1)
//   maj_bit     : 2-of-3 majority of the bit samples
// ----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] presc,
    output logic               bit_end,
    output logic               maj_valid,
    output logic               maj_bit
);

    localparam logic [PRESC_W-1:0] ONE_L  = PRESC_W'(1'b1);
    localparam logic [PRESC_W-1:0] ZERO_L = {PRESC_W{1'b0}};

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic               s0_q, s0_d;
    logic               s1_q, s1_d;
    logic [PRESC_W-1:0] half_s;
    logic [PRESC_W-1:0] last_s;

    assign half_s = {1'b0, presc[PRESC_W-1:1]};
    assign last_s = presc - ONE_L;

    // Edge counter advance and early-sample capture
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        if (!run) begin
            edge_cnt_d = ZERO_L;
        end else if (edge_cnt_q == last_s) begin
            edge_cnt_d = ZERO_L;
        end else begin
            edge_cnt_d = edge_cnt_q + ONE_L;
        end
        if (run && (edge_cnt_q == (half_s - ONE_L))) begin
            s0_d = rx_in;
        end else begin
            s0_d = s0_q;
        end
        if (run && (edge_cnt_q == half_s)) begin
            s1_d = rx_in;
        end else begin
            s1_d = s1_q;
        end
    end

    // Edge counter and sample registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= ZERO_L;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
        end
    end

    // The third sample is the live line so the vote lands at P/2+1 itself.
    assign maj_bit   = maj3(s0_q, s1_q, rx_in);
    assign maj_valid = run && (edge_cnt_q == (half_s + ONE_L));
    assign bit_end   = run && (edge_cnt_q == last_s);

endmodule

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
// UART frame receiver: start-bit qualification, LSB-first data (5..DATA_W_MAX
// bits), optional even/odd parity, one or two stop bits, break detection.
// Frame configuration is latched at the start-bit edge so mid-frame changes
// are ignored. Results are registered and appear one cycle after the frame
// ends; the frame ends at the vote point of its last stop bit so a new start
// bit right after it is not missed.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   rx_if      : slave side of uart_rx_ctrl_if (line, configuration, results)
// ----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W_MAX = DATA_W_MAX_DEF,
    parameter int PRESC_W    = PRESC_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_ctrl_if.slave rx_if
);

    localparam logic [3:0]            LEN_MIN_L   = 4'(LEN_MIN);
    localparam logic [3:0]            LEN_MAX_L   = 4'(DATA_W_MAX);
    localparam logic [PRESC_W-1:0]    PRESC_MIN_L = PRESC_W'(PRESC_MIN);
    localparam logic [DATA_W_MAX-1:0] DZERO_L     = {DATA_W_MAX{1'b0}};

    rx_state_e             state_q, state_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [3:0]            len_q, len_d;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic                  stop2_q, stop2_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_W_MAX-1:0] shreg_q, shreg_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_flag_q, par_flag_d;
    logic                  stp_flag_q, stp_flag_d;
    logic [DATA_W_MAX-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  brk_det_q, brk_det_d;
    logic                  busy_q, busy_d;

    logic                  run_s;
    logic                  bit_end_s;
    logic                  maj_valid_s;
    logic                  maj_bit_s;
    logic [3:0]            len_clamp_s;
    logic [PRESC_W-1:0]    presc_clamp_s;
    logic [DATA_W_MAX-1:0] justified_s;
    logic                  exp_par_s;
    logic                  zero_frame_s;
    logic                  stp_final_s;

    assign run_s = (state_q != ST_IDLE);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run_s),
        .rx_in     (rx_if.rx_in),
        .presc     (presc_q),
        .bit_end   (bit_end_s),
        .maj_valid (maj_valid_s),
        .maj_bit   (maj_bit_s)
    );

    // Clamp the live configuration into the supported range
    always_comb begin
        len_clamp_s   = rx_if.data_len;
        presc_clamp_s = rx_if.prescale;
        if (rx_if.data_len < LEN_MIN_L) begin
            len_clamp_s = LEN_MIN_L;
        end else if (rx_if.data_len > LEN_MAX_L) begin
            len_clamp_s = LEN_MAX_L;
        end else begin
            len_clamp_s = rx_if.data_len;
        end
        if (rx_if.prescale < PRESC_MIN_L) begin
            presc_clamp_s = PRESC_MIN_L;
        end else begin
            presc_clamp_s = rx_if.prescale;
        end
    end

    // Bits enter at the top and move down, so a short word sits in the upper
    // bits and is shifted down by the unused width to right-justify it.
    assign justified_s  = shreg_q >> (LEN_MAX_L - len_q);
    assign exp_par_s    = exp_parity(16'(shreg_q), par_odd_q);
    assign zero_frame_s = (shreg_q == DZERO_L) && !(par_en_q && par_bit_q);
    assign stp_final_s  = stp_flag_q | ~maj_bit_s;

    // Next-state and result logic
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        len_d        = len_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        stop2_d      = stop2_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        par_flag_d   = par_flag_q;
        stp_flag_d   = stp_flag_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        brk_det_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_if.rx_in) begin
                    state_d    = ST_START;
                    presc_d    = presc_clamp_s;
                    len_d      = len_clamp_s;
                    par_en_d   = rx_if.par_en;
                    par_odd_d  = rx_if.par_odd;
                    stop2_d    = rx_if.stop2;
                    bit_cnt_d  = 4'd0;
                    shreg_d    = DZERO_L;
                    par_bit_d  = 1'b0;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                // A start bit that votes high was a glitch
                if (maj_valid_s && maj_bit_s) begin
                    state_d = ST_IDLE;
                end else if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (maj_valid_s) begin
                    shreg_d   = {maj_bit_s, shreg_q[DATA_W_MAX-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (bit_end_s && (bit_cnt_q == len_q)) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (maj_valid_s) begin
                    par_bit_d  = maj_bit_s;
                    par_flag_d = (maj_bit_s != exp_par_s);
                end else if (bit_end_s) begin
                    state_d = ST_STOP1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (maj_valid_s) begin
                    if (!maj_bit_s && zero_frame_s) begin
                        brk_det_d  = 1'b1;
                        data_out_d = justified_s;
                        state_d    = ST_BREAK_WAIT;
                    end else if (stop2_q) begin
                        stp_flag_d = stp_final_s;
                    end else begin
                        data_out_d   = justified_s;
                        state_d      = ST_IDLE;
                        par_err_d    = par_flag_q;
                        stp_err_d    = stp_final_s;
                        data_valid_d = ~(par_flag_q | stp_final_s);
                    end
                end else if (bit_end_s && stop2_q) begin
                    state_d = ST_STOP2;
                end else begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (maj_valid_s) begin
                    data_out_d   = justified_s;
                    state_d      = ST_IDLE;
                    par_err_d    = par_flag_q;
                    stp_err_d    = stp_final_s;
                    data_valid_d = ~(par_flag_q | stp_final_s);
                end else begin
                    state_d = ST_STOP2;
                end
            end
            ST_BREAK_WAIT: begin
                if (rx_if.rx_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Frame state, configuration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= PRESC_MIN_L;
            len_q        <= LEN_MIN_L;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop2_q      <= 1'b0;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= DZERO_L;
            par_bit_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            stp_flag_q   <= 1'b0;
            data_out_q   <= DZERO_L;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            brk_det_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            len_q        <= len_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            stop2_q      <= stop2_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            par_flag_q   <= par_flag_d;
            stp_flag_q   <= stp_flag_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            brk_det_q    <= brk_det_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_if.data_out   = data_out_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.par_err    = par_err_q;
    assign rx_if.stp_err    = stp_err_q;
    assign rx_if.brk_det    = brk_det_q;
    assign rx_if.busy       = busy_q;

endmodule
